display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexed driver for a bank of common-anode seven-segment digits on the board. It holds a multi-digit hex value, scans one digit at a time through a single shared hex-to-seven-segment decode path, and drives the active-low anode enables. It inserts a blanking gap between digits to prevent ghosting, and commits new values only at frame boundaries so a display update never tears. Upstream logic writes values through a valid/ready handshake.

## Interface
- `NUM_DIGITS`, 4: digits scanned; 2..8.
- `TICK_DIV`, 50000: clock cycles per digit slot; > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 500: cycles per slot with all anodes off; >= 1.

- `clk`  in  1  single system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  upstream offers a new frame.
- `load_ready`  out  1  pending buffer empty; a load is accepted on `load_valid && load_ready`.
- `load_data`  in  4*NUM_DIGITS  hex nibbles; digit 0 (rightmost) = `[3:0]`.
- `load_dp`  in  NUM_DIGITS  decimal-point enables, captured with `load_data`.
- `lz_en`  in  1  leading-zero suppression enable, sampled live.
- `seg_n`  out  7  segments, active-low; bit0 = a … bit6 = g.
- `dp_n`  out  1  decimal point, active-low.
- `an_n`  out  NUM_DIGITS  digit enables, active-low, at most one low.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Registers:
  - active frame: data + dp, displayed.
  - pending frame: data + dp + `pend_vld`.
  - digit index `idx`: 0..NUM_DIGITS-1.
  - slot counter `cnt`: 0..TICK_DIV-1.
  - state.
- FSM states:
  - BLANK: entered with `cnt=0`; leave for SHOW when `cnt==BLANK_CYCLES-1`.
  - SHOW: leave when `cnt==TICK_DIV-1`. On leaving, go to BLANK, reset `cnt` to 0, and advance `idx` (wrapping NUM_DIGITS-1 -> 0).
- Outputs in BLANK: `an_n` all 1, `seg_n=7'h7F`, `dp_n=1`.
- Outputs in SHOW:
  - `an_n` has bit `idx` low.
  - `seg_n` is the decode of active nibble `idx`.
  - `dp_n = ~active_dp[idx]`.
- Hex decode, `seg_n` values:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero suppression (`lz_en=1`):
  - A digit `k>0` is suppressed if it and all higher digits are 0 in the active frame.
  - A suppressed slot behaves as BLANK for its whole duration (anode stays high); `dp` is suppressed too.
  - Digit 0 is never suppressed.
- Load:
  - Accepted while `pend_vld=0`. Captures data and dp into pending and sets `pend_vld`; `load_ready` drops next cycle.
- Commit:
  - On the edge where `idx` wraps to 0: if `pend_vld`, active <= pending and `pend_vld` <= 0.
  - `load_ready` rises on that same edge.
- Simultaneous load and commit: impossible for the same buffer, since load requires `pend_vld=0`. A load accepted on the commit edge lands in pending and commits at the next wrap.
- `frame_tick` is asserted for the cycle following the wrap edge.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values:
  - `an_n` all 1, `seg_n=7'h7F`, `dp_n=1`, `frame_tick=0`, `load_ready=1`.
  - Active frame all 0, `pend_vld=0`, `idx=0`, `cnt=0`, state BLANK.
- Slot = exactly `TICK_DIV` cycles; frame = `NUM_DIGITS*TICK_DIV` cycles.
- First anode low is `BLANK_CYCLES` cycles after reset release.
- Load-to-display latency: at most one frame plus `BLANK_CYCLES`.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously), and the pending frame is discarded.
- `lz_en` toggling takes effect at the next slot boundary; it never cuts into an active SHOW.

## Structure
- Shared package `display_pkg`:
  - `seg7_t` (7-bit) typedef.
  - `SEG_BLANK = 7'h7F`.
  - Hex-to-segment function `hex_to_seg7` (the encoding above), reused by all display blocks.
- One sub-module: `scan_tick_gen`, the slot counter plus BLANK/SHOW FSM, emitting `show`, `slot_end` and `wrap`.
- The top level holds the frame buffers, `idx`, suppression logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
1. Reset, then idle:
   - Required: `an_n=4'b1111`, `seg_n=7'h7F`, `load_ready=1`.
   - After 2 cycles, `an_n=4'b1110` with `seg_n=1000000`.
2. Load `16'h12AF` with `dp=0`, then wait for `frame_tick`:
   - slot0: `an_n=1110`, `seg_n=0001110`.
   - slot1: `an_n=1101`, `seg_n=0001000`.
   - slot3: `an_n=0111`, `seg_n=1111001`.
3. `lz_en=1`, load `16'h0050`:
   - Slots 3 and 2: `an_n` stays 1111.
   - slot1: `seg_n=0010010`.
   - slot0: `seg_n=1000000`.
4. Two back-to-back loads (`16'h1111`, then `16'h2222`) within one frame:
   - Second load stalls with `load_ready=0` until the wrap edge.
   - No frame ever shows mixed digits; `2222` appears exactly one frame after `1111`.
5. `load_dp=4'b0100` with data `16'h3140`: `dp_n=0` only in slot2.
6. Assert `rst_n=0` in the middle of slot1 SHOW:
   - Same-cycle `an_n=1111`.
   - After release, the scan restarts at slot0 with active frame 0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared seven-segment types, blank pattern and hex decode
package display_pkg;
  typedef logic [6:0] seg7_t;
  typedef enum logic {BLANK, SHOW} scan_state_t;
  localparam seg7_t SEG_BLANK = 7'h7F;
  function automatic seg7_t hex_to_seg7(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: per-slot counter with BLANK/SHOW sequencing
module scan_tick_gen
  import display_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic last,
  output logic show,
  output logic slot_end,
  output logic wrap
);
  localparam int CW = $clog2(TICK_DIV);
  scan_state_t   state;
  logic [CW-1:0] cnt;
  assign slot_end = state == SHOW && cnt == CW'(TICK_DIV - 1);
  // show is the state of the coming cycle, so registered pins line up with the FSM
  assign show     = state == BLANK ? cnt == CW'(BLANK_CYCLES - 1) : !slot_end;
  assign wrap     = slot_end && last;
  // step BLANK -> SHOW -> BLANK once per slot, restarting the count each slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
    end else begin
      state <= show ? SHOW : BLANK;
      cnt   <= slot_end ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexed seven-segment scan with tear-free frame loads
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lz_en,
  output seg7_t                   seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [4*NUM_DIGITS-1:0] act_data, pend_data;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
  logic [IW-1:0]           idx;
  logic [3:0]              nib;
  logic pend_vld, lz_q, show, slot_end, wrap, last, supp, lit;
  scan_tick_gen #(.TICK_DIV(TICK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_tick (
    .clk(clk), .rst_n(rst_n), .last(last), .show(show), .slot_end(slot_end), .wrap(wrap)
  );
  assign last       = idx == IW'(NUM_DIGITS - 1);
  assign load_ready = ~pend_vld;
  assign nib        = 4'(act_data >> {idx, 2'b00});
  // lz_q only changes at slot boundaries, so suppression never cuts into a lit digit
  assign supp       = lz_q && idx != '0 && (act_data >> {idx, 2'b00}) == '0;
  assign lit        = show && !supp;
  // frame buffers, scan index and per-slot suppression mode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act_data  <= '0;
      act_dp    <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_vld  <= 1'b0;
      idx       <= '0;
      lz_q      <= 1'b0;
    end else begin
      if (slot_end) begin
        idx  <= last ? '0 : idx + 1'b1;
        lz_q <= lz_en;
      end
      if (wrap && pend_vld) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        pend_vld <= 1'b0;
      end else if (load_valid && !pend_vld) begin
        pend_data <= load_data;
        pend_dp   <= load_dp;
        pend_vld  <= 1'b1;
      end
    end
  // registered pin drive: one anode low only while the current digit is lit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      an_n       <= '1;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg_n      <= lit ? hex_to_seg7(nib) : SEG_BLANK;
      dp_n       <= !(lit && act_dp[idx]);
      frame_tick <= wrap;
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed checks of scan timing, decode, suppression, loads and reset
module tb_display_scan_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;
  int checks = 0;
  int errors = 0;

  display_scan_controller #(.NUM_DIGITS(4), .TICK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .lz_en(lz_en), .seg_n(seg_n),
    .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // leaves the bench on the negedge where frame_tick is visible (cnt=0, idx=0)
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 200);
    checks++;
    if (!frame_tick) begin
      errors++;
      $display("FAIL frame_tick_timeout got %0d cycles without pulse", n);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    load_valid = 1'b1;
    load_data  = d;
    load_dp    = dp;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL rst_an got %b want 1111", an_n); end
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL rst_seg got %b want 1111111", seg_n); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL rst_dp got %b want 1", dp_n); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", load_ready); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", frame_tick); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL idle_blank1 got %b want 1111", an_n); end
    @(negedge clk);
    checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL idle_an got %b want 1110", an_n); end
    checks++; if (seg_n !== 7'b1000000) begin errors++; $display("FAIL idle_seg got %b want 1000000", seg_n); end
  endtask

  task automatic test_decode;
    int n;
    wait_frame(n);
    load(16'h12AF, 4'b0000);
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_drop got %b want 0", load_ready); end
    wait_frame(n);
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_rise got %b want 1", load_ready); end
    repeat (4) @(negedge clk);
    checks++; if (an_n !== 4'b1110 || seg_n !== 7'b0001110) begin errors++; $display("FAIL t2_slot0 got %b/%b want 1110/0001110", an_n, seg_n); end
    repeat (8) @(negedge clk);
    checks++; if (an_n !== 4'b1101 || seg_n !== 7'b0001000) begin errors++; $display("FAIL t2_slot1 got %b/%b want 1101/0001000", an_n, seg_n); end
    repeat (8) @(negedge clk);
    checks++; if (an_n !== 4'b1011 || seg_n !== 7'b0100100) begin errors++; $display("FAIL t2_slot2 got %b/%b want 1011/0100100", an_n, seg_n); end
    repeat (8) @(negedge clk);
    checks++; if (an_n !== 4'b0111 || seg_n !== 7'b1111001 || dp_n !== 1'b1) begin errors++; $display("FAIL t2_slot3 got %b/%b/%b want 0111/1111001/1", an_n, seg_n, dp_n); end
  endtask

  task automatic test_lz;
    int n;
    lz_en = 1'b1;
    wait_frame(n);
    load(16'h0050, 4'b0000);
    wait_frame(n);
    repeat (4) @(negedge clk);
    checks++; if (an_n !== 4'b1110 || seg_n !== 7'b1000000) begin errors++; $display("FAIL t3_slot0 got %b/%b want 1110/1000000", an_n, seg_n); end
    repeat (8) @(negedge clk);
    checks++; if (an_n !== 4'b1101 || seg_n !== 7'b0010010) begin errors++; $display("FAIL t3_slot1 got %b/%b want 1101/0010010", an_n, seg_n); end
    repeat (8) @(negedge clk);
    checks++; if (an_n !== 4'b1111 || seg_n !== 7'h7F) begin errors++; $display("FAIL t3_slot2 got %b/%b want 1111/1111111", an_n, seg_n); end
    repeat (8) @(negedge clk);
    checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL t3_slot3 got %b want 1111", an_n); end
    lz_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    wait_frame(n);
    load_valid = 1'b1;
    load_data  = 16'h1111;
    @(negedge clk);
    load_data = 16'h2222;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_ready && n < 100);
    checks++; if (n !== 31) begin errors++; $display("FAIL t4_stall got %0d cycles want 31", n); end
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL t4_ready_on_wrap got tick %b want 1", frame_tick); end
    @(negedge clk);
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL t4_second_accept got ready %b want 0", load_ready); end
    repeat (3) @(negedge clk);
    checks++; if (an_n !== 4'b1110 || seg_n !== 7'b1111001) begin errors++; $display("FAIL t4_f1_slot0 got %b/%b want 1110/1111001", an_n, seg_n); end
    repeat (24) @(negedge clk);
    checks++; if (an_n !== 4'b0111 || seg_n !== 7'b1111001) begin errors++; $display("FAIL t4_f1_slot3 got %b/%b want 0111/1111001", an_n, seg_n); end
    wait_frame(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL t4_frame_gap got %0d want 4", n); end
    repeat (4) @(negedge clk);
    checks++; if (an_n !== 4'b1110 || seg_n !== 7'b0100100) begin errors++; $display("FAIL t4_f2_slot0 got %b/%b want 1110/0100100", an_n, seg_n); end
    repeat (24) @(negedge clk);
    checks++; if (an_n !== 4'b0111 || seg_n !== 7'b0100100) begin errors++; $display("FAIL t4_f2_slot3 got %b/%b want 0111/0100100", an_n, seg_n); end
  endtask

  task automatic test_dp;
    int n;
    wait_frame(n);
    load(16'h3140, 4'b0100);
    wait_frame(n);
    repeat (4) @(negedge clk);
    checks++; if (dp_n !== 1'b1 || seg_n !== 7'b1000000) begin errors++; $display("FAIL t5_slot0 got dp %b seg %b want 1/1000000", dp_n, seg_n); end
    repeat (8) @(negedge clk);
    checks++; if (dp_n !== 1'b1 || seg_n !== 7'b0011001) begin errors++; $display("FAIL t5_slot1 got dp %b seg %b want 1/0011001", dp_n, seg_n); end
    repeat (5) @(negedge clk);
    checks++; if (dp_n !== 1'b1 || an_n !== 4'b1111) begin errors++; $display("FAIL t5_slot2_blank got dp %b an %b want 1/1111", dp_n, an_n); end
    repeat (3) @(negedge clk);
    checks++; if (dp_n !== 1'b0 || seg_n !== 7'b1111001) begin errors++; $display("FAIL t5_slot2 got dp %b seg %b want 0/1111001", dp_n, seg_n); end
    repeat (8) @(negedge clk);
    checks++; if (dp_n !== 1'b1 || seg_n !== 7'b0110000) begin errors++; $display("FAIL t5_slot3 got dp %b seg %b want 1/0110000", dp_n, seg_n); end
  endtask

  task automatic test_async_reset;
    int n;
    wait_frame(n);
    repeat (10) @(negedge clk);
    load(16'h9999, 4'b1111);
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL t6_pend got ready %b want 0", load_ready); end
    @(negedge clk);
    checks++; if (an_n !== 4'b1101) begin errors++; $display("FAIL t6_pre_an got %b want 1101", an_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (an_n !== 4'b1111 || seg_n !== 7'h7F || dp_n !== 1'b1) begin errors++; $display("FAIL t6_async got %b/%b/%b want 1111/1111111/1", an_n, seg_n, dp_n); end
    checks++; if (load_ready !== 1'b1 || frame_tick !== 1'b0) begin errors++; $display("FAIL t6_async_ctl got ready %b tick %b want 1/0", load_ready, frame_tick); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (an_n !== 4'b1110 || seg_n !== 7'b1000000) begin errors++; $display("FAIL t6_restart got %b/%b want 1110/1000000", an_n, seg_n); end
    repeat (10) @(negedge clk);
    checks++; if (an_n !== 4'b1101 || seg_n !== 7'b1000000) begin errors++; $display("FAIL t6_slot1 got %b/%b want 1101/1000000", an_n, seg_n); end
    wait_frame(n);
    checks++; if (n !== 20) begin errors++; $display("FAIL t6_wrap_time got %0d want 20", n); end
    repeat (4) @(negedge clk);
    checks++; if (seg_n !== 7'b1000000) begin errors++; $display("FAIL t6_discard got %b want 1000000", seg_n); end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_lz;
    test_back_to_back;
    test_dp;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
